// File: rtl/packet_buffer_pkg.sv
// packet_buffer_pkg: frame-length limits and FSM state type shared by the packet assembler
package packet_buffer_pkg;
  localparam int MAX_ETH_FRAME_LENGTH = 1518;
  localparam int PKT_LEN_WIDTH = $clog2(MAX_ETH_FRAME_LENGTH + 1);
  typedef enum logic {IDLE, STREAM} assembler_state_t;
endpackage

// File: rtl/packet_assembler_keep_gen.sv
// packet_assembler_keep_gen: thermometer mask with the low need_i lanes set
module packet_assembler_keep_gen #(
  parameter int NUM_LANES = 8,
  localparam int NW = $clog2(NUM_LANES + 1)
) (
  input  logic [NW-1:0]        need_i,
  output logic [NUM_LANES-1:0] keep_o
);
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_keep
    assign keep_o[g] = need_i > NW'(g);
  end
endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: gathers per-lane byte streams into AXI4-Stream beats of a descriptor-given length
// Optional PACKET_ASSEMBLER_STATS_EN adds wrapping packet and byte counters.
module packet_assembler
  import packet_buffer_pkg::*;
#(
  parameter int AXI_WIDTH = 64,
  parameter int LANE_WIDTH = 8,
  localparam int NUM_LANES = AXI_WIDTH / LANE_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PKT_LEN_WIDTH-1:0] len_i,
  input  logic                     len_valid_i,
  output logic                     len_ready_o,
  input  logic [LANE_WIDTH-1:0]    lane_tdata_i [NUM_LANES],
  input  logic [NUM_LANES-1:0]     lane_tvalid_i,
  output logic [NUM_LANES-1:0]     lane_tready_o,
  output logic [AXI_WIDTH-1:0]     tdata_o,
  output logic [NUM_LANES-1:0]     tkeep_o,
  output logic                     tlast_o,
  output logic                     tvalid_o,
  input  logic                     tready_i,
  output logic                     err_len_o
`ifdef PACKET_ASSEMBLER_STATS_EN
  ,
  output logic [31:0]              pkt_count_o,
  output logic [31:0]              byte_count_o
`endif
);
  localparam int NW = $clog2(NUM_LANES + 1);
  localparam logic [PKT_LEN_WIDTH-1:0] LANES_L = PKT_LEN_WIDTH'(NUM_LANES);
  localparam logic [PKT_LEN_WIDTH-1:0] MAX_L = PKT_LEN_WIDTH'(MAX_ETH_FRAME_LENGTH);

  assembler_state_t         state_q;
  logic [PKT_LEN_WIDTH-1:0] rem_q;
  logic                     len_ready_q, err_q, tvalid_q, tlast_q;
  logic [NUM_LANES-1:0]     tkeep_q, keep;
  logic [AXI_WIDTH-1:0]     tdata_q, data_d;
  logic [NW-1:0]            need;
  logic                     accept, len_ok, last, form;

  assign need   = (rem_q < LANES_L) ? NW'(rem_q) : NW'(NUM_LANES);
  assign last   = rem_q <= LANES_L;
  assign accept = len_valid_i && len_ready_q;
  assign len_ok = (len_i != '0) && (len_i <= MAX_L);
  // A beat needs every required lane at once and room in the output register
  assign form   = (state_q == STREAM) && ((lane_tvalid_i & keep) == keep) && (!tvalid_q || tready_i);

  packet_assembler_keep_gen #(.NUM_LANES(NUM_LANES)) u_keep_gen (
    .need_i(need),
    .keep_o(keep)
  );

  // Pack the required lanes into the beat, zeroing the unused bytes
  always_comb begin
    data_d = '0;
    for (int i = 0; i < NUM_LANES; i++) data_d[i*LANE_WIDTH +: LANE_WIDTH] = keep[i] ? lane_tdata_i[i] : '0;
  end

  // Descriptor FSM, remaining-byte count and the registered output beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      len_ready_q <= 1'b0;
      err_q       <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tkeep_q     <= '0;
      tdata_q     <= '0;
    end else begin
      err_q       <= accept && !len_ok;
      len_ready_q <= !(accept && len_ok) && (state_q == IDLE || (form && last));
      if (form) begin
        tvalid_q <= 1'b1;
        tdata_q  <= data_d;
        tkeep_q  <= keep;
        tlast_q  <= last;
        rem_q    <= rem_q - PKT_LEN_WIDTH'(need);
        if (last) state_q <= IDLE;
      end else if (tvalid_q && tready_i) begin
        tvalid_q <= 1'b0;
      end
      if (accept && len_ok) begin
        state_q <= STREAM;
        rem_q   <= len_i;
      end
    end
  end

  assign len_ready_o   = len_ready_q;
  assign err_len_o     = err_q;
  assign lane_tready_o = form ? keep : '0;
  assign tdata_o       = tdata_q;
  assign tkeep_o       = tkeep_q;
  assign tlast_o       = tlast_q;
  assign tvalid_o      = tvalid_q;

`ifdef PACKET_ASSEMBLER_STATS_EN
  logic [31:0] pkt_count_q, byte_count_q;
  // Wrapping counters of delivered packets and bytes, advanced on each output handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_count_q  <= '0;
      byte_count_q <= '0;
    end else if (tvalid_q && tready_i) begin
      pkt_count_q  <= pkt_count_q + 32'(tlast_q);
      byte_count_q <= byte_count_q + 32'($countones(tkeep_q));
    end
  end
  assign pkt_count_o  = pkt_count_q;
  assign byte_count_o = byte_count_q;
`endif
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: randomized self-checking bench with a per-packet beat model
module tb_packet_assembler;
  import packet_buffer_pkg::*;
  localparam int AW = 64, LW = 8, NL = 8;

  logic clk = 0, rst_ni = 1;
  logic [PKT_LEN_WIDTH-1:0] len_i = '0;
  logic len_valid_i = 0, len_ready_o;
  logic [LW-1:0] lane_tdata_i [NL];
  logic [NL-1:0] lane_tvalid_i = '1, lane_tready_o;
  logic [AW-1:0] tdata_o;
  logic [NL-1:0] tkeep_o;
  logic tlast_o, tvalid_o, tready_i = 1, err_len_o;
`ifdef PACKET_ASSEMBLER_STATS_EN
  logic [31:0] pkt_count_o, byte_count_o;
`endif

  always #5 clk = ~clk;

  packet_assembler #(.AXI_WIDTH(AW), .LANE_WIDTH(LW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .len_i(len_i), .len_valid_i(len_valid_i), .len_ready_o(len_ready_o),
    .lane_tdata_i(lane_tdata_i), .lane_tvalid_i(lane_tvalid_i), .lane_tready_o(lane_tready_o),
    .tdata_o(tdata_o), .tkeep_o(tkeep_o), .tlast_o(tlast_o), .tvalid_o(tvalid_o), .tready_i(tready_i),
    .err_len_o(err_len_o)
`ifdef PACKET_ASSEMBLER_STATS_EN
    , .pkt_count_o(pkt_count_o), .byte_count_o(byte_count_o)
`endif
  );

  typedef struct packed {logic [AW-1:0] data; logic [NL-1:0] keep; logic last;} beat_t;
  beat_t obs[$], exp_q[$];
  int obs_cyc[$];
  logic [LW-1:0] seq [NL][4096];
  int pops[NL], midx[NL];
  int cyc = 0, errs_seen = 0, errors = 0, checks = 0;

  // Each lane source presents its next byte from a fixed random sequence
  always_comb for (int i = 0; i < NL; i++) lane_tdata_i[i] = seq[i][pops[i]];

  // A lane advances only after the edge at which it was actually popped
  always @(negedge clk) begin
    logic [NL-1:0] pend;
    pend = lane_tready_o & lane_tvalid_i;
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) if (pend[i]) pops[i]++;
  end

  // Collect completed output handshakes and error pulses
  always @(negedge clk) begin
    cyc++;
    if (err_len_o) errs_seen++;
    if (rst_ni && tvalid_o && tready_i) begin
      obs.push_back({tdata_o, tkeep_o, tlast_o});
      obs_cyc.push_back(cyc);
    end
  end

  // Reference: a packet of len bytes is ceil(len/NL) beats, each taking the next byte of lanes 0..need-1
  function automatic void build(int len);
    int rem;
    rem = len;
    while (rem > 0) begin
      int need;
      beat_t b;
      need = rem < NL ? rem : NL;
      b = '0;
      for (int i = 0; i < need; i++) begin
        b.data[i*LW +: LW] = seq[i][midx[i]];
        midx[i]++;
      end
      b.keep = NL'((1 << need) - 1);
      b.last = rem <= NL;
      exp_q.push_back(b);
      rem -= need;
    end
  endfunction

  function automatic int first_bad();
    if (obs.size() != exp_q.size()) return -2;
    foreach (exp_q[k]) if (obs[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  function automatic bit pops_ok();
    for (int i = 0; i < NL; i++) if (pops[i] != midx[i]) return 0;
    return 1;
  endfunction

  function automatic void clear();
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endfunction

  task automatic send_desc(int len);
    int t;
    t = 0;
    while (!len_ready_o && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (!len_ready_o) begin errors++; $display("FAIL desc_ready got=%b want=1", len_ready_o); end
    len_i = PKT_LEN_WIDTH'(len);
    len_valid_i = 1;
    @(posedge clk);
    #1;
    len_valid_i = 0;
  endtask

  task automatic wait_beats(int n, bit rnd);
    int t;
    t = 0;
    while (obs.size() < n && t < 2000) begin
      if (rnd) begin
        tready_i = $urandom_range(0, 3) != 0;
        lane_tvalid_i = NL'($urandom) | NL'($urandom);
      end
      @(posedge clk);
      #1;
      t++;
    end
    tready_i = 1;
    lane_tvalid_i = '1;
    checks++;
    if (obs.size() < n) begin errors++; $display("FAIL beat_timeout got=%0d want=%0d", obs.size(), n); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_first();
    int t;
    t = 0;
    while (obs.size() < 1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic test_reset();
    #1 rst_ni = 0;
    #2;
    checks++;
    if ({tvalid_o, tlast_o, err_len_o, len_ready_o} !== 4'b0 || tkeep_o !== '0 || tdata_o !== '0 || lane_tready_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b e=%b r=%b k=%h d=%h lr=%h want all 0", tvalid_o, tlast_o, err_len_o, len_ready_o, tkeep_o, tdata_o, lane_tready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (len_ready_o !== 1'b0) begin errors++; $display("FAIL reset_len_ready got=%b want=0", len_ready_o); end
    rst_ni = 1;
    @(posedge clk);
    #1;
    checks++;
    if (len_ready_o !== 1'b1 || tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got ready=%b valid=%b want ready=1 valid=0", len_ready_o, tvalid_o);
    end
  endtask

  task automatic test_full();
    int bad;
    clear();
    build(64);
    send_desc(64);
    wait_beats(8, 0);
    bad = first_bad();
    checks++;
    if (bad != -1) begin errors++; $display("FAIL full_beats idx=%0d got_n=%0d want_n=8", bad, obs.size()); end
    checks++;
    if (obs.size() == 8 && obs_cyc[7] - obs_cyc[0] != 7) begin
      errors++;
      $display("FAIL full_rate got_span=%0d want=7", obs_cyc[7] - obs_cyc[0]);
    end
    checks++;
    if (!pops_ok()) begin errors++; $display("FAIL full_pops got lane0=%0d want=%0d", pops[0], midx[0]); end
  endtask

  task automatic test_partial();
    int bad, p5;
    clear();
    p5 = pops[5];
    build(13);
    send_desc(13);
    wait_beats(2, 0);
    bad = first_bad();
    checks++;
    if (bad != -1) begin errors++; $display("FAIL partial_beats idx=%0d got_n=%0d want_n=2", bad, obs.size()); end
    checks++;
    if (pops[5] - p5 != 1 || !pops_ok()) begin errors++; $display("FAIL partial_pops got lane5=%0d want=1", pops[5] - p5); end
  endtask

  task automatic test_bad_len();
    int e0, bad;
    clear();
    e0 = errs_seen;
    send_desc(0);
    repeat (2) @(posedge clk);
    #1;
    send_desc(1600);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (errs_seen - e0 != 2) begin errors++; $display("FAIL err_pulses got=%0d want=2", errs_seen - e0); end
    checks++;
    if (obs.size() != 0 || !pops_ok()) begin errors++; $display("FAIL bad_len_quiet got beats=%0d lane0_pops=%0d want 0 and %0d", obs.size(), pops[0], midx[0]); end
    build(1);
    send_desc(1);
    wait_beats(1, 0);
    bad = first_bad();
    checks++;
    if (bad != -1) begin errors++; $display("FAIL len1_beat idx=%0d got_n=%0d want_n=1", bad, obs.size()); end
  endtask

  task automatic test_stall();
    int bad;
    clear();
    build(24);
    send_desc(24);
    wait_first();
    tready_i = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (!tvalid_o || {tdata_o, tkeep_o, tlast_o} !== exp_q[1] || lane_tready_o !== '0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h k=%h pop=%h want v=1 d=%h k=%h pop=0", k, tvalid_o, tdata_o, tkeep_o, lane_tready_o, exp_q[1].data, exp_q[1].keep);
      end
    end
    @(posedge clk);
    #1;
    tready_i = 1;
    wait_beats(3, 0);
    bad = first_bad();
    checks++;
    if (bad != -1 || !pops_ok()) begin errors++; $display("FAIL stall_beats idx=%0d got_n=%0d want_n=3", bad, obs.size()); end
  endtask

  task automatic test_lane_stall();
    int bad;
    clear();
    build(32);
    send_desc(32);
    wait_first();
    lane_tvalid_i[3] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (lane_tready_o !== '0) begin errors++; $display("FAIL lane_stall_pop cyc=%0d got=%h want=00", k, lane_tready_o); end
    end
    @(posedge clk);
    #1;
    lane_tvalid_i = '1;
    wait_beats(4, 0);
    bad = first_bad();
    checks++;
    if (bad != -1 || !pops_ok()) begin errors++; $display("FAIL lane_stall_beats idx=%0d got_n=%0d want_n=4", bad, obs.size()); end
  endtask

  task automatic test_back_to_back();
    int bad, len;
    clear();
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 100);
      build(len);
      send_desc(len);
      wait_beats(exp_q.size(), 1);
    end
    bad = first_bad();
    checks++;
    if (bad != -1) begin errors++; $display("FAIL random_beats idx=%0d got_n=%0d want_n=%0d", bad, obs.size(), exp_q.size()); end
    checks++;
    if (!pops_ok()) begin errors++; $display("FAIL random_pops got lane0=%0d want=%0d", pops[0], midx[0]); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bit saw_last;
    clear();
    send_desc(64);
    wait_first();
    #1 rst_ni = 0;
    #1;
    saw_last = 0;
    foreach (obs[k]) saw_last |= obs[k].last;
    checks++;
    if (tvalid_o !== 1'b0 || lane_tready_o !== '0 || len_ready_o !== 1'b0 || saw_last) begin
      errors++;
      $display("FAIL reset_mid got v=%b pop=%h r=%b last_seen=%b want 0", tvalid_o, lane_tready_o, len_ready_o, saw_last);
    end
    @(posedge clk);
    #3 rst_ni = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) midx[i] = pops[i];
    checks++;
    if (len_ready_o !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got=%b want=1", len_ready_o); end
    clear();
    build(8);
    send_desc(8);
    wait_beats(1, 0);
    bad = first_bad();
    checks++;
    if (bad != -1) begin errors++; $display("FAIL reset_mid_beat idx=%0d got_n=%0d want_n=1", bad, obs.size()); end
`ifdef PACKET_ASSEMBLER_STATS_EN
    checks++;
    if (pkt_count_o !== 32'd1 || byte_count_o !== 32'd8) begin
      errors++;
      $display("FAIL stats got pkt=%0d bytes=%0d want pkt=1 bytes=8", pkt_count_o, byte_count_o);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < NL; i++) for (int j = 0; j < 4096; j++) seq[i][j] = LW'($urandom);
    test_reset();
    test_full();
    test_partial();
    test_bad_len();
    test_stall();
    test_lane_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 64: output AXI4-Stream data width in bits.
REQ-002 SHALL have parameter LANE_WIDTH, default 8: per-lane input data width in bits; NUM_LANES = AXI_WIDTH/LANE_WIDTH.
REQ-003 SHALL have port clk_i, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port len_i, input, PKT_LEN_WIDTH: packet length in bytes (descriptor).
REQ-006 SHALL have ports len_valid_i (input, 1) and len_ready_o (output, 1): descriptor handshake.
REQ-007 SHALL have ports lane_tdata_i[NUM_LANES] (input, LANE_WIDTH each), lane_tvalid_i[NUM_LANES] (input, 1 each) and lane_tready_o[NUM_LANES] (output, 1 each): per-lane byte streams.
REQ-008 SHALL have ports tdata_o (output, AXI_WIDTH), tkeep_o (output, NUM_LANES), tlast_o (output, 1), tvalid_o (output, 1) and tready_i (input, 1): AXI4-Stream master.
REQ-009 SHALL have port err_len_o, output, 1: one-cycle pulse when a descriptor is rejected.

Function
REQ-010 SHALL implement the states IDLE and STREAM.
REQ-011 SHALL assert len_ready_o only in IDLE.
REQ-012 SHALL, on a descriptor accept with 1 <= len_i <= MAX_ETH_FRAME_LENGTH, load the remaining-byte counter with len_i and enter STREAM.
REQ-013 SHALL, on a descriptor accept with len_i == 0 or len_i > MAX_ETH_FRAME_LENGTH, drop the descriptor, pulse err_len_o, and stay in IDLE.
REQ-014 SHALL, per beat, require need = min(remaining, NUM_LANES) lanes, namely lanes 0..need-1.
REQ-015 SHALL form a beat only when all lanes 0..need-1 have lane_tvalid_i high and the output register is empty or draining (tvalid_o && tready_i).
REQ-016 SHALL assert lane_tready_o[i] only for i < need, and only in the cycle a beat is formed; no lane SHALL ever be popped partially.
REQ-017 SHALL place byte of lane i at tdata_o[i*LANE_WIDTH +: LANE_WIDTH] and zero unused bytes.
REQ-018 SHALL set tkeep_o bit i = (i < need).
REQ-019 SHALL set tlast_o = (remaining <= NUM_LANES).
REQ-020 SHALL register the output: a beat formed in cycle N is presented with tvalid_o high in cycle N+1.
REQ-021 SHALL hold tdata_o/tkeep_o/tlast_o stable while tvalid_o && !tready_i.
REQ-022 SHALL sustain one beat per cycle when all lanes are valid and tready_i is held high.
REQ-023 SHALL decrement remaining by need per formed beat and return to IDLE in the cycle after the tlast beat is formed; one IDLE cycle separates packets.
REQ-024 SHALL ignore lane_tvalid_i in IDLE.

Reset
REQ-025 SHALL, while rst_ni is low, asynchronously force: state=IDLE, remaining=0, tvalid_o=0, tlast_o=0, tkeep_o=0, tdata_o=0, err_len_o=0, all lane_tready_o=0, len_ready_o=0.
REQ-026 SHALL, on reset mid-packet, discard the partial packet with no tlast; len_ready_o SHALL rise in the first cycle after deassertion.

Configuration
REQ-027 SHALL, with PACKET_ASSEMBLER_STATS_EN defined, add outputs pkt_count_o[31:0] (increment on each tlast handshake) and byte_count_o[31:0] (add popcount(tkeep_o) on each handshake); both wrap, reset 0.
REQ-028 SHALL, without PACKET_ASSEMBLER_STATS_EN, omit those ports and counters entirely.

Structure
REQ-029 SHALL take MAX_ETH_FRAME_LENGTH, PKT_LEN_WIDTH = $clog2(MAX_ETH_FRAME_LENGTH+1) and the state enum assembler_state_t from packet_buffer_pkg.
REQ-030 SHALL contain exactly one sub-module, packet_assembler_keep_gen, mapping need to the tkeep mask.

Verification
REQ-031 len=64, all lanes valid, tready_i=1 -> 8 beats on consecutive cycles, tkeep=0xFF throughout, tlast on beat 8 only.
REQ-032 len=13 -> beat1 tkeep=0xFF tlast=0; beat2 tkeep=0x1F tlast=1, upper 3 bytes zero; lanes 5-7 popped once only.
REQ-033 len=0, then len=1600 -> two err_len_o pulses, no output beats, no lane pops; then len=1 -> single beat tkeep=0x01 tlast=1.
REQ-034 len=24, tready_i low for 5 cycles on beat 2 -> beat 2 held stable, no lane pops during the stall, 3 beats total.
REQ-035 lane 3 tvalid_i low for 4 cycles mid-packet -> no beat formed and no lane popped until lane 3 is valid.
REQ-036 rst_ni low for 1 cycle mid-packet, then len=8 -> tvalid_o=0 immediately at assertion; new packet emits 1 beat tkeep=0xFF tlast=1; with STATS_EN, pkt_count_o=1 and byte_count_o=8.
